uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameters: DLY, default 1, register update delay in ns; DATA_WIDTH, default 8, max character width; FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-002 SHALL have ports: clk_i  in  1  primary clock.
REQ-003 rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 data_bits  in  4  character length (5..8; <5 treated as 5, >8 treated as 8).
REQ-005 parity_mode  in  2  0 none, 1 odd, 2 even, 3 none.
REQ-006 stop_bits  in  2  0/1 one stop bit, 2/3 two stop bits.
REQ-007 br16_en_i  in  1  single-cycle 16x-oversample tick.
REQ-008 rx_i  in  1  asynchronous serial line, idle high.
REQ-009 ur_rx_ctrl_data_o  out  DATA_WIDTH  FIFO head, received character zero-extended.
REQ-010 ur_rx_ctrl_vld_o  out  1  FIFO non-empty.
REQ-011 ur_rx_ctrl_rdy_i  in  1  consumer accept.
REQ-012 ur_rx_fifo_full_o / ur_rx_fifo_empty_o  out  1 each  FIFO state.
REQ-013 parity_err_o / frame_err_o / overrun_o  out  1 each  single-cycle error pulses.

Function
REQ-014 rx_i SHALL pass a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value.
REQ-015 Receiver FSM SHALL have states IDLE, START, DATA, PARITY, STOP; a 4-bit sample counter advances only on br16_en_i.
REQ-016 IDLE -> START on a br16_en_i cycle with synchronized rx low; counter cleared.
REQ-017 START: at counter 7 (mid-bit) rx high -> IDLE (glitch, no error); rx low -> DATA, counter restarts.
REQ-018 DATA: sample at counter 7 of each bit, LSB first, data_bits bits; then PARITY if parity_mode is 1 or 2, else STOP.
REQ-019 PARITY: mid-bit sample compared with XOR of received bits (odd: XOR^1); mismatch flags parity error for the frame.
REQ-020 STOP: each stop bit sampled mid-bit; sample 0 flags frame error; after the last stop sample FSM SHALL return to IDLE immediately (no wait for bit end).
REQ-021 Frame completion cycle: frame error -> frame_err_o pulse, character discarded; else parity error -> parity_err_o pulse, character discarded; else character pushed.
REQ-022 Push while FIFO full and no pop in the same cycle SHALL drop the character and pulse overrun_o; FIFO contents unchanged.
REQ-023 FIFO SHALL be first-word-fall-through: vld_o = ~empty, data_o = head entry; pop when vld_o && rdy_i.
REQ-024 Simultaneous push and pop SHALL both take effect (including when full); occupancy unchanged.
REQ-025 Pointers wrap modulo FIFO_DEPTH; full/empty derived from extra-MSB pointer compare, registered with the pointers.
REQ-026 Latency: vld_o rises one clk after the completion cycle when FIFO was empty.
REQ-027 Configuration inputs SHALL be sampled at START->DATA and held for the frame; mid-frame changes affect only the next frame.
REQ-028 rdy_i with FIFO empty SHALL have no effect.

Reset
REQ-029 On rst_n_i low: FSM IDLE, counters 0, shift register 0, pointers 0, empty_o 1, full_o 0, vld_o 0, data_o 0, all error pulses 0, synchronizer 1.
REQ-030 Reset mid-frame SHALL abort the frame; no partial character ever enters the FIFO; first frame after release requires a fresh falling edge.

Verification
REQ-031 8N1, tick every 4 clk, send 0xA5, rdy_i=1 -> one vld_o cycle, data_o=0xA5, no error pulses.
REQ-032 7E1, send 0x35 with inverted parity bit -> parity_err_o one pulse, vld_o stays 0; next frame 0x12 correct -> data_o=0x12.
REQ-033 8N2, second stop bit driven 0 -> frame_err_o pulse, FIFO empty; rx then idle, frame 0x7E -> received 0x7E.
REQ-034 rdy_i=0, send 9 frames 0x00..0x08 (depth 8) -> full_o after 8th, overrun_o on 9th; drain yields 0x00..0x07 in order, then empty_o=1.
REQ-035 rx low for 5 ticks then high (glitch) -> FSM returns IDLE, no push, no error; reset asserted mid-DATA of 0x55 -> no output, next 0x3C received intact.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle of the UART receiver: FIFO head/handshake, FIFO
// status and the per-frame error pulses.
//   master : driven by the receiver (data/vld/full/empty/errors out, rdy in)
//   slave  : used by the consumer (rdy out, everything else in)
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] ur_rx_ctrl_data_o;
  logic                  ur_rx_ctrl_vld_o;
  logic                  ur_rx_ctrl_rdy_i;
  logic                  ur_rx_fifo_full_o;
  logic                  ur_rx_fifo_empty_o;
  logic                  parity_err_o;
  logic                  frame_err_o;
  logic                  overrun_o;

  modport master (
    output ur_rx_ctrl_data_o, ur_rx_ctrl_vld_o, ur_rx_fifo_full_o,
           ur_rx_fifo_empty_o, parity_err_o, frame_err_o, overrun_o,
    input  ur_rx_ctrl_rdy_i
  );

  modport slave (
    input  ur_rx_ctrl_data_o, ur_rx_ctrl_vld_o, ur_rx_fifo_full_o,
           ur_rx_fifo_empty_o, parity_err_o, frame_err_o, overrun_o,
    output ur_rx_ctrl_rdy_i
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver with 16x oversampling and a first-word-fall-through
// receive FIFO.
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   data_bits          : character length 5..8 (clamped)
//   parity_mode        : 0/3 none, 1 odd, 2 even
//   stop_bits          : 0/1 one stop bit, 2/3 two
//   br16_en_i          : one-cycle 16x baud tick
//   rx_i               : asynchronous serial line, idle high
//   rx_if (master)     : FIFO head data/valid/ready, full/empty,
//                        parity/frame/overrun pulses
module uart_rx_ctrl #(
  parameter int DLY        = 1,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [3:0]     data_bits,
  input  logic [1:0]     parity_mode,
  input  logic [1:0]     stop_bits,
  input  logic           br16_en_i,
  input  logic           rx_i,
  uart_rx_ctrl_if.master rx_if
);
  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_BITS = (DATA_WIDTH < 8) ? 4'(DATA_WIDTH) : 4'd8;

  // Registers update with zero delay here; DLY only exists so integrations
  // that pass it keep elaborating.
  if (DLY < 0) begin : g_dly_neg
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- synchronizer ----------------
  logic r_rx_meta, r_rx_sync;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  // ---------------- receiver FSM ----------------
  state_t                r_state, w_state_n;
  logic [3:0]            r_cnt, r_bitcnt, r_nbits, w_nbits;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parx, r_par_en, r_par_odd, r_two_stop, r_stop_idx;
  logic                  r_perr, r_ferr;
  logic                  w_mid, w_cnt_clr, w_cfg_ld, w_smp_data, w_smp_par, w_smp_stop, w_done;

  always_comb begin
    w_nbits = data_bits;
    if (data_bits < 4'd5)          w_nbits = 4'd5;
    else if (data_bits > MAX_BITS) w_nbits = MAX_BITS;
  end

  // The sample counter free-runs modulo 16 once a start edge is seen, so
  // count 7 stays the mid-point of every following bit.
  assign w_mid = br16_en_i && (r_cnt == 4'd7);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_clr  = 1'b0;
    w_cfg_ld   = 1'b0;
    w_smp_data = 1'b0;
    w_smp_par  = 1'b0;
    w_smp_stop = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: if (br16_en_i && !r_rx_sync) begin
        w_state_n = S_START;
        w_cnt_clr = 1'b1;
      end
      S_START: if (w_mid) begin
        if (r_rx_sync) w_state_n = S_IDLE;   // start glitch, drop silently
        else begin
          w_state_n = S_DATA;
          w_cfg_ld  = 1'b1;
        end
      end
      S_DATA: if (w_mid) begin
        w_smp_data = 1'b1;
        if (r_bitcnt == r_nbits - 4'd1) w_state_n = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_mid) begin
        w_smp_par = 1'b1;
        w_state_n = S_STOP;
      end
      S_STOP: if (w_mid) begin
        w_smp_stop = 1'b1;
        // Leave at the last stop mid-point so a back-to-back start edge is seen.
        if (r_stop_idx == r_two_stop) begin
          w_done    = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_nbits    <= 4'd8;
      r_shift    <= '0;
      r_parx     <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop_idx <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if (br16_en_i) r_cnt <= w_cnt_clr ? 4'd0 : r_cnt + 4'd1;
      if (w_cfg_ld) begin
        r_nbits    <= w_nbits;
        r_par_en   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
        r_par_odd  <= (parity_mode == 2'd1);
        r_two_stop <= (stop_bits >= 2'd2);
        r_bitcnt   <= '0;
        r_shift    <= '0;
        r_parx     <= 1'b0;
        r_stop_idx <= 1'b0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
      end
      if (w_smp_data) begin
        for (int i = 0; i < DATA_WIDTH; i++)
          if (r_bitcnt == 4'(i)) r_shift[i] <= r_rx_sync;
        r_bitcnt <= r_bitcnt + 4'd1;
        r_parx   <= r_parx ^ r_rx_sync;
      end
      if (w_smp_par)  r_perr <= r_rx_sync != (r_parx ^ r_par_odd);
      if (w_smp_stop) begin
        if (!r_rx_sync) r_ferr <= 1'b1;
        r_stop_idx <= 1'b1;
      end
    end
  end

  // Frame error outranks parity error; only clean frames reach the FIFO.
  logic w_ferr_now, w_ferr_pls, w_perr_pls, w_push_req;
  assign w_ferr_now = r_ferr | ~r_rx_sync;
  assign w_ferr_pls = w_done & w_ferr_now;
  assign w_perr_pls = w_done & ~w_ferr_now & r_perr;
  assign w_push_req = w_done & ~w_ferr_now & ~r_perr;

  // ---------------- receive FIFO ----------------
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr, r_rptr, w_wptr_n, w_rptr_n;
  logic                  r_full, r_empty, w_pop, w_wr, w_ovr;
  logic                  r_perr_o, r_ferr_o, r_ovr_o;

  assign w_pop    = ~r_empty & rx_if.ur_rx_ctrl_rdy_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr     = w_push_req & (~r_full | w_pop);
  assign w_ovr    = w_push_req & r_full & ~w_pop;
  assign w_wptr_n = r_wptr + (AW+1)'(w_wr);
  assign w_rptr_n = r_rptr + (AW+1)'(w_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr_o  <= 1'b0;
    end else begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
      r_wptr   <= w_wptr_n;
      r_rptr   <= w_rptr_n;
      r_empty  <= (w_wptr_n == w_rptr_n);
      r_full   <= (w_wptr_n[AW] != w_rptr_n[AW]) && (w_wptr_n[AW-1:0] == w_rptr_n[AW-1:0]);
      r_perr_o <= w_perr_pls;
      r_ferr_o <= w_ferr_pls;
      r_ovr_o  <= w_ovr;
    end
  end

  assign rx_if.ur_rx_ctrl_data_o  = r_mem[r_rptr[AW-1:0]];
  assign rx_if.ur_rx_ctrl_vld_o   = ~r_empty;
  assign rx_if.ur_rx_fifo_full_o  = r_full;
  assign rx_if.ur_rx_fifo_empty_o = r_empty;
  assign rx_if.parity_err_o       = r_perr_o;
  assign rx_if.frame_err_o        = r_ferr_o;
  assign rx_if.overrun_o          = r_ovr_o;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level model (bit builder + expected FIFO
// contents + expected error-event order) and one per-cycle compare process.
module tb_uart_rx_ctrl;
  localparam int K_NONE = 0, K_PERR = 1, K_FERR = 2, K_OVR = 3, K_OK = 4;
  localparam int DEPTH  = 8;

  logic       clk = 1'b0, rst_n = 1'b0, br16 = 1'b0, rx = 1'b1;
  logic [3:0] data_bits   = 4'd8;
  logic [1:0] parity_mode = 2'd0, stop_bits = 2'd0;

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) ifc();

  uart_rx_ctrl #(.DLY(1), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_bits(data_bits), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .br16_en_i(br16), .rx_i(rx), .rx_if(ifc)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int vld_cnt = 0, pop_cnt = 0;
  logic [7:0] mq[$];   // characters the FIFO must deliver, in order
  int         evq[$];  // error/overrun pulses expected, in order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial image of one frame, LSB first from the start bit, plus outcome.
  function automatic void build(input logic [7:0] ch, input logic [3:0] db, input logic [1:0] pm,
                                input logic [1:0] sb, input bit bad_par, input bit bad_stop2,
                                output logic [15:0] fb, output int len, output int outc,
                                output logic [7:0] ec);
    int  n, ones, stops;
    bit  p, has_par;
    n = (db < 5) ? 5 : ((db > 8) ? 8 : int'(db));
    fb = '0; len = 0; ones = 0;
    fb[len] = 1'b0; len++;
    for (int i = 0; i < n; i++) begin
      fb[len] = ch[i]; ones += int'(ch[i]); len++;
    end
    has_par = (pm == 2'd1) || (pm == 2'd2);
    if (has_par) begin
      p = ((ones % 2) == 1) ^ (pm == 2'd1);
      if (bad_par) p = !p;
      fb[len] = p; len++;
    end
    stops = (sb >= 2) ? 2 : 1;
    for (int s = 0; s < stops; s++) begin
      fb[len] = (bad_stop2 && s == 1) ? 1'b0 : 1'b1; len++;
    end
    if (bad_stop2 && stops == 2)   outc = K_FERR;
    else if (bad_par && has_par)   outc = K_PERR;
    else                           outc = K_OK;
    ec = ch & 8'((1 << n) - 1);
  endfunction

  task automatic drive_bits(input logic [15:0] fb, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; rx = fb[i];
      repeat (63) @(posedge clk);
    end
  endtask

  task automatic drive_idle(input int n);
    @(posedge clk); #1; rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] ch, input bit bad_par, input bit bad_stop2);
    logic [15:0] fb; int len, outc; logic [7:0] ec;
    build(ch, data_bits, parity_mode, stop_bits, bad_par, bad_stop2, fb, len, outc, ec);
    if (outc == K_OK) begin
      if (mq.size() < DEPTH) mq.push_back(ec);
      else                   evq.push_back(K_OVR);
    end else evq.push_back(outc);
    drive_bits(fb, len);
    drive_idle(72);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " vld"},   ifc.ur_rx_ctrl_vld_o,   1'b0);
    chk({tag, " empty"}, ifc.ur_rx_fifo_empty_o, 1'b1);
    chk({tag, " full"},  ifc.ur_rx_fifo_full_o,  1'b0);
    chk({tag, " data"},  ifc.ur_rx_ctrl_data_o,  8'h00);
    chk({tag, " pulses"}, {ifc.parity_err_o, ifc.frame_err_o, ifc.overrun_o}, 3'b000);
  endtask

  // 16x tick every 4 clocks
  initial begin
    int tc = 0;
    forever begin
      @(posedge clk); #1;
      tc = (tc + 1) % 4;
      br16 = (tc == 0);
    end
  end

  // Per-cycle compare against the model queues.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      chk("vld_vs_empty", ifc.ur_rx_ctrl_vld_o, !ifc.ur_rx_fifo_empty_o);
      if (ifc.ur_rx_ctrl_vld_o) vld_cnt++;
      if (ifc.ur_rx_ctrl_vld_o && ifc.ur_rx_ctrl_rdy_i) begin
        pop_cnt++;
        e = (mq.size() != 0) ? 32'(mq.pop_front()) : 32'hDEAD_BEEF;
        chk("pop data", 32'(ifc.ur_rx_ctrl_data_o), e);
      end
      if (ifc.parity_err_o) begin
        e = (evq.size() != 0) ? 32'(evq.pop_front()) : K_NONE;
        chk("parity_err event", K_PERR, e);
      end
      if (ifc.frame_err_o) begin
        e = (evq.size() != 0) ? 32'(evq.pop_front()) : K_NONE;
        chk("frame_err event", K_FERR, e);
      end
      if (ifc.overrun_o) begin
        e = (evq.size() != 0) ? 32'(evq.pop_front()) : K_NONE;
        chk("overrun event", K_OVR, e);
      end
    end
  end

  initial begin
    logic [15:0] fb; int len, outc; logic [7:0] ec;
    ifc.ur_rx_ctrl_rdy_i = 1'b0;

    // model pins (hand-computed frame images)
    build(8'hA5, 4'd8, 2'd0, 2'd0, 1'b0, 1'b0, fb, len, outc, ec);
    chk("model 8N1 A5 bits", fb, 16'h034A);
    chk("model 8N1 len", len, 10);
    build(8'h35, 4'd7, 2'd2, 2'd0, 1'b1, 1'b0, fb, len, outc, ec);
    chk("model 7E1 bad-par bits", fb, 16'h036A);
    chk("model 7E1 outcome", outc, K_PERR);
    build(8'hFF, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0, fb, len, outc, ec);
    chk("model clamp len", len, 7);
    chk("model clamp char", ec, 8'h1F);

    // reset state
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    drive_idle(40);

    // 8N1, 0xA5, consumer ready
    ifc.ur_rx_ctrl_rdy_i = 1'b1;
    vld_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("8N1 vld cycles", vld_cnt, 1);
    chk("8N1 pop count", pop_cnt, 1);

    // 7E1 bad parity then good 0x12
    data_bits = 4'd7; parity_mode = 2'd2; stop_bits = 2'd0;
    vld_cnt = 0;
    send_frame(8'h35, 1'b1, 1'b0);
    chk("7E1 bad-par vld cycles", vld_cnt, 0);
    send_frame(8'h12, 1'b0, 1'b0);
    chk("7E1 good pop count", pop_cnt, 2);

    // 8N2 bad second stop, then good 0x7E
    data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 2'd2;
    vld_cnt = 0;
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("8N2 ferr vld cycles", vld_cnt, 0);
    @(negedge clk);
    chk("8N2 ferr empty", ifc.ur_rx_fifo_empty_o, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b0);
    chk("8N2 good pop count", pop_cnt, 3);

    // fill to full and overrun with consumer stalled
    stop_bits = 2'd0;
    ifc.ur_rx_ctrl_rdy_i = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("full after 8", ifc.ur_rx_fifo_full_o, 1'b1);
    chk("head after 8", ifc.ur_rx_ctrl_data_o, 8'h00);
    send_frame(8'h08, 1'b0, 1'b0);
    @(negedge clk);
    chk("full after overrun", ifc.ur_rx_fifo_full_o, 1'b1);
    chk("head after overrun", ifc.ur_rx_ctrl_data_o, 8'h00);
    pop_cnt = 0;
    @(posedge clk); #1; ifc.ur_rx_ctrl_rdy_i = 1'b1;
    for (int i = 0; i < 100 && !ifc.ur_rx_fifo_empty_o; i++) @(negedge clk);
    @(negedge clk);
    chk("drain empty", ifc.ur_rx_fifo_empty_o, 1'b1);
    chk("drain pops", pop_cnt, 8);

    // start glitch: low for 5 ticks
    vld_cnt = 0;
    @(posedge clk); #1; rx = 1'b0;
    repeat (20) @(posedge clk);
    drive_idle(200);
    chk("glitch vld cycles", vld_cnt, 0);

    // reset in the middle of the data bits of 0x55
    build(8'h55, 4'd8, 2'd0, 2'd0, 1'b0, 1'b0, fb, len, outc, ec);
    drive_bits(fb, 4);
    @(posedge clk); #1; rst_n = 1'b0; rx = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid-frame reset");
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b1;
    vld_cnt = 0;
    drive_idle(300);
    chk("post-reset vld cycles", vld_cnt, 0);
    pop_cnt = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("post-reset pop count", pop_cnt, 1);

    chk("leftover events", evq.size(), 0);
    chk("leftover chars", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
